// File: rtl/fifo_uart_pkg.sv
// Shared sizing constants for the UART data-path FIFO.
package fifo_uart_pkg;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

endpackage

// File: rtl/fifo_uart_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one registered read port.
module fifo_uart_mem
    import fifo_uart_pkg::*;
#(
    parameter int DW    = DATA_W,
    parameter int DEP   = DEPTH,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEP];

    // Storage is deliberately left unreset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_uart.sv
// 16550-style 16 x 8 FIFO with full/empty flags, overrun/underrun pulses and a fill-level trigger.
module fifo_uart
    import fifo_uart_pkg::*;
#(
    parameter int DW  = DATA_W,
    parameter int DEP = DEPTH,
    parameter int AW  = ADDR_W
) (
    output logic          thres_trig,
    output logic          overrun,
    output logic          underrun,
    output logic          empty,
    output logic          full,
    output logic [DW-1:0] dout,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] thres_hold,
    input  logic          clk,
    input  logic          rst,
    input  logic          push_in,
    input  logic          pop_in,
    input  logic          en
);

    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;

    logic do_push;
    logic do_pop;
    logic wr_ok;
    logic rd_ok;

    assign do_push = en & push_in;
    assign do_pop  = en & pop_in;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEP));

    // A pop on a full FIFO frees a slot in the same edge, so the push is accepted too.
    assign rd_ok = do_pop & ~empty;
    assign wr_ok = do_push & (~full | rd_ok);

    assign thres_trig = (thres_hold != '0) && (count >= {1'b0, thres_hold});

    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_next;
            overrun  <= do_push & ~wr_ok;
            underrun <= do_pop & ~rd_ok;
        end
    end

    fifo_uart_mem #(
        .DW  (DW),
        .DEP (DEP),
        .AW  (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (din),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_fifo_uart.sv
// Scoreboard bench for fifo_uart: a queue model of the FIFO predicts data, flags and error pulses.
module tb_fifo_uart;

    logic       clk;
    logic       rst;
    logic       push_in;
    logic       pop_in;
    logic       en;
    logic [7:0] din;
    logic [3:0] thres_hold;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       overrun;
    logic       underrun;
    logic       thres_trig;

    int total = 0;
    int bad   = 0;

    logic [7:0] fifo_q [$];
    logic [7:0] exp_q  [$];
    logic [7:0] model_dout;
    logic       exp_ovr;
    logic       exp_und;

    fifo_uart dut (
        .thres_trig (thres_trig),
        .overrun    (overrun),
        .underrun   (underrun),
        .empty      (empty),
        .full       (full),
        .dout       (dout),
        .din        (din),
        .thres_hold (thres_hold),
        .clk        (clk),
        .rst        (rst),
        .push_in    (push_in),
        .pop_in     (pop_in),
        .en         (en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic exp_trig();
        return (thres_hold != 4'd0) && (fifo_q.size() >= int'(thres_hold));
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".dout"},  32'(dout),       32'(model_dout));
        check({tag, ".empty"}, 32'(empty),      32'(fifo_q.size() == 0));
        check({tag, ".full"},  32'(full),       32'(fifo_q.size() == 16));
        check({tag, ".trig"},  32'(thres_trig), 32'(exp_trig()));
        check({tag, ".ovr"},   32'(overrun),    32'(exp_ovr));
        check({tag, ".und"},   32'(underrun),   32'(exp_und));
    endtask

    task automatic model_reset();
        fifo_q.delete();
        exp_q.delete();
        model_dout = 8'h00;
        exp_ovr    = 1'b0;
        exp_und    = 1'b0;
    endtask

    // Called at posedge+1; drives one cycle of stimulus and checks the result after the edge.
    task automatic step(input string tag, input logic p, input logic q, input logic e, input logic [7:0] d);
        logic dp, dq, rd_ok, wr_ok;
        push_in = p;
        pop_in  = q;
        en      = e;
        din     = d;
        dp      = p & e;
        dq      = q & e;
        rd_ok   = dq && (fifo_q.size() != 0);
        wr_ok   = dp && ((fifo_q.size() < 16) || rd_ok);
        exp_ovr = dp && !wr_ok;
        exp_und = dq && !rd_ok;
        if (rd_ok) exp_q.push_back(fifo_q.pop_front());
        if (wr_ok) fifo_q.push_back(d);
        @(posedge clk);
        #1;
        if (exp_q.size() != 0) model_dout = exp_q.pop_front();
        check_all(tag);
        push_in = 1'b0;
        pop_in  = 1'b0;
        en      = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        push_in    = 1'b0;
        pop_in     = 1'b0;
        en         = 1'b0;
        din        = 8'h00;
        thres_hold = 4'd0;
        model_reset();

        repeat (5) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        thres_hold = 4'd10;
        for (int i = 0; i < 20; i++) step("fill", 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 20; i++) step("drain", 1'b0, 1'b1, 1'b1, 8'h00);

        for (int i = 0; i < 16; i++) step("refill", 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
        step("pp_full", 1'b1, 1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < 16; i++) step("drain2", 1'b0, 1'b1, 1'b1, 8'h00);
        step("pp_empty", 1'b1, 1'b1, 1'b1, 8'h3C);

        step("en_off", 1'b1, 1'b1, 1'b0, 8'hFF);
        step("en_off2", 1'b1, 1'b0, 1'b0, 8'hEE);
        step("pop_last", 1'b0, 1'b1, 1'b1, 8'h00);

        thres_hold = 4'd0;
        for (int i = 0; i < 12; i++) step("wrap_push", 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 12; i++) step("wrap_pop", 1'b0, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 16; i++) step("wrap_fill", 1'b1, 1'b0, 1'b1, 8'($urandom_range(0, 255)));
        for (int i = 0; i < 16; i++) step("wrap_drain", 1'b0, 1'b1, 1'b1, 8'h00);

        for (int i = 0; i < 5; i++) step("lvl_push", 1'b1, 1'b0, 1'b1, 8'(i + 8'h40));
        for (int t = 0; t < 16; t++) begin
            thres_hold = 4'(t);
            #1;
            check("thres_sweep", 32'(thres_trig), 32'(exp_trig()));
        end

        thres_hold = 4'd3;
        step("pre_rst_pop", 1'b0, 1'b1, 1'b1, 8'h00);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("post_rst_push", 1'b1, 1'b0, 1'b1, 8'h5A);
        step("post_rst_pop", 1'b0, 1'b1, 1'b1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
